// File: rtl/fft_input_framer.sv
// fft_input_framer: collects a valid/ready sample stream into N-sample frames
// in a ping-pong double buffer and replays each full frame to the FFT in
// bit-reversed order, one sample per cycle, with frame starts spaced by at
// least GAP cycles.
module fft_input_framer #(
    parameter int N     = 8,
    parameter int WIDTH = 8,
    parameter int GAP   = 16
) (
    input  logic             fastclock,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             readyin,
    output logic [WIDTH-1:0] x,
    output logic [7:0]       frames_sent
);

    localparam int LOGN = $clog2(N);
    localparam int CW   = $clog2(GAP + 1);
    localparam logic [LOGN-1:0] PTR_LAST = LOGN'(N - 1);
    // Last WAIT count; only meaningful when GAP > N.
    localparam logic [CW-1:0] CNT_LAST = (GAP > N) ? CW'(GAP - N - 1) : {CW{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Reverse the LOGN address bits to produce the FFT input ordering.
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        r = {LOGN{1'b0}};
        for (int i = 0; i < LOGN; i++) begin
            r[i] = v[LOGN-1-i];
        end
        return r;
    endfunction

    // Storage: two banks of N samples, plus one full flag per bank.
    logic [WIDTH-1:0] mem [0:1][0:N-1];
    logic [1:0]       full_r;

    // Write side state.
    logic             wbank_r;
    logic [LOGN-1:0]  wptr_r;
    logic             wr_fire_s;
    logic             wr_last_s;
    logic [1:0]       full_set_s;

    // Read side state.
    state_t           state_r, state_next_s;
    logic             rbank_r, rbank_next_s;
    logic [LOGN-1:0]  rptr_r, rptr_next_s;
    logic [CW-1:0]    cnt_r, cnt_next_s;
    logic             readyin_next_s;
    logic [WIDTH-1:0] x_next_s;
    logic [7:0]       frames_next_s;
    logic             rd_done_s;
    logic [1:0]       full_clr_s;

    // The writer may only fill a bank that the reader has released.
    assign s_ready   = !full_r[wbank_r] && !n_rst;
    assign wr_fire_s = s_valid && s_ready;
    assign wr_last_s = wr_fire_s && (wptr_r == PTR_LAST);

    // Decode which bank flag is set by the writer and cleared by the reader.
    always_comb begin
        full_set_s = 2'b00;
        full_clr_s = 2'b00;
        if (wr_last_s) begin
            full_set_s[wbank_r] = 1'b1;
        end else begin
            full_set_s = 2'b00;
        end
        if (rd_done_s) begin
            full_clr_s[rbank_r] = 1'b1;
        end else begin
            full_clr_s = 2'b00;
        end
    end

    // Write pointer and write bank advance on every accepted sample.
    always_ff @(posedge fastclock) begin
        if (n_rst) begin
            wbank_r <= 1'b0;
            wptr_r  <= {LOGN{1'b0}};
        end else if (wr_fire_s) begin
            if (wptr_r == PTR_LAST) begin
                wptr_r  <= {LOGN{1'b0}};
                wbank_r <= ~wbank_r;
            end else begin
                wptr_r  <= wptr_r + {{(LOGN-1){1'b0}}, 1'b1};
            end
        end
    end

    // Sample storage; contents survive reset because the full flags gate use.
    always_ff @(posedge fastclock) begin
        if (wr_fire_s) begin
            mem[wbank_r][wptr_r] <= s_data;
        end
    end

    // Full flags: writer and reader always own different banks, so a set and
    // a clear in the same cycle land on different bits.
    always_ff @(posedge fastclock) begin
        if (n_rst) begin
            full_r <= 2'b00;
        end else begin
            full_r <= (full_r | full_set_s) & ~full_clr_s;
        end
    end

    // Read FSM next-state and next-output logic.
    always_comb begin
        state_next_s   = state_r;
        rbank_next_s   = rbank_r;
        rptr_next_s    = rptr_r;
        cnt_next_s     = cnt_r;
        readyin_next_s = 1'b0;
        x_next_s       = {WIDTH{1'b0}};
        frames_next_s  = frames_sent;
        rd_done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (full_r[rbank_r]) begin
                    state_next_s = SEND;
                    rptr_next_s  = {LOGN{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                readyin_next_s = 1'b1;
                x_next_s       = mem[rbank_r][bitrev(rptr_r)];
                if (rptr_r == PTR_LAST) begin
                    rd_done_s     = 1'b1;
                    rbank_next_s  = ~rbank_r;
                    frames_next_s = frames_sent + 8'd1;
                    rptr_next_s   = {LOGN{1'b0}};
                    cnt_next_s    = {CW{1'b0}};
                    if (GAP > N) begin
                        state_next_s = WAIT;
                    end else if (full_r[~rbank_r]) begin
                        // Next bank already waiting: keep the spacing exact.
                        state_next_s = SEND;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    rptr_next_s = rptr_r + {{(LOGN-1){1'b0}}, 1'b1};
                end
            end
            WAIT: begin
                if (cnt_r == CNT_LAST) begin
                    rptr_next_s = {LOGN{1'b0}};
                    if (full_r[rbank_r]) begin
                        state_next_s = SEND;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Read FSM state and registered FFT-side outputs.
    always_ff @(posedge fastclock) begin
        if (n_rst) begin
            state_r     <= IDLE;
            rbank_r     <= 1'b0;
            rptr_r      <= {LOGN{1'b0}};
            cnt_r       <= {CW{1'b0}};
            readyin     <= 1'b0;
            x           <= {WIDTH{1'b0}};
            frames_sent <= 8'd0;
        end else begin
            state_r     <= state_next_s;
            rbank_r     <= rbank_next_s;
            rptr_r      <= rptr_next_s;
            cnt_r       <= cnt_next_s;
            readyin     <= readyin_next_s;
            x           <= x_next_s;
            frames_sent <= frames_next_s;
        end
    end

endmodule

// File: doc/fft_input_framer.md
# fft_input_framer

Upstream stage of the `fft` block. It accepts a stream of 8-bit samples over a valid/ready handshake and collects them into N-sample frames in a ping-pong double buffer. Each complete frame is replayed to the FFT on `readyin`/`x` in bit-reversed order, one sample per cycle. Frame starts are spaced at least GAP cycles apart so the FFT can finish each transform before the next frame arrives.

## Interface
- N, 8: samples per frame; power of two, 4..16; LOGN = log2(N)
- WIDTH, 8: sample width
- GAP, 16: minimum cycles from one frame's first `readyin` beat to the next frame's first beat; GAP ≥ N
- fastclock  in  1  sole clock, rising edge
- n_rst  in  1  synchronous, active-high reset (1 = reset), sampled on `fastclock`
- s_data  in  WIDTH  input sample
- s_valid  in  1  `s_data` valid
- s_ready  out  1  framer can accept; transfer on `s_valid && s_ready`
- readyin  out  1  FFT input strobe; high for exactly N consecutive cycles per frame
- x  out  WIDTH  sample to FFT, valid while `readyin` = 1; 0 otherwise
- frames_sent  out  8  count of completed frames, wraps 255→0

## Operation
- **Storage:** two banks A/B of N×WIDTH; one `full` flag per bank.
- **Write side:** holds `wbank` (reset A) and `wptr` (LOGN bits, reset 0).
  - On a transfer: `mem[wbank][wptr] <= s_data`, `wptr++`.
  - At `wptr` = N-1: set `full[wbank]`, toggle `wbank`, wrap `wptr` to 0.
  - `s_ready = !full[wbank] && !n_rst` (combinational).
- **Read FSM:** IDLE, SEND, WAIT; `rbank` reset A; `rptr` LOGN bits.
  - IDLE: if `full[rbank]` and spacing is satisfied, go to SEND with `rptr` = 0.
  - SEND: registered `readyin` = 1 and `x = mem[rbank][bitrev(rptr)]`; `rptr++` each cycle. On the beat with `rptr` = N-1: clear `full[rbank]`, toggle `rbank`, increment `frames_sent`, go to WAIT. If GAP = N, go directly to IDLE/SEND instead.
  - WAIT: count GAP-N cycles, then go to IDLE (or straight to SEND if the other bank is already full, so spacing is exact).
- **Bit reversal:** reverse the LOGN bits of `rptr`. For N = 8 the order is 0,4,2,6,1,5,3,7.
- **No data loss:** samples are never dropped or duplicated; back-pressure is applied only through `s_ready`.
- **Reset:** a frame partly written or partly sent is discarded. While `n_rst` = 1 on an edge:
  - both `full` flags = 0, `wptr` = `rptr` = 0, `wbank` = `rbank` = A
  - state = IDLE, `readyin` = 0, `x` = 0, `frames_sent` = 0
  - memory contents need not be cleared.

## Timing
- All outputs except `s_ready` are registered. `s_ready` is 0 during reset and 1 in the first cycle after reset is released.
- **Latency:** the last sample of a frame is accepted at edge t. If the FSM is idle and spacing is satisfied, `readyin` is high from edge t+2 to edge t+N+1 inclusive.
- **Spacing:** if the first beat of a frame is at cycle T, the next first beat is exactly at T+GAP when a full bank is waiting, and never earlier.
- **Bank release:** a bank's `full` clears at the edge that ends its last SEND beat. If the writer was stalled on that bank, `s_ready` rises in the next cycle.
- **Bank ownership:** the writer and reader always own different banks when both are active, so setting and clearing `full` never collide on one bank. Setting `full` on one bank and clearing it on the other in the same cycle are both honoured.
- `readyin` never goes low mid-frame; N beats are always contiguous.

## Test plan
- **Reset values:** hold `n_rst` = 1 for 2 cycles → `readyin` = 0, `x` = 0, `frames_sent` = 0, `s_ready` = 0; `s_ready` = 1 in the cycle after release.
- **Single frame (N=8):** push 0x10..0x17 back-to-back → `readyin` high 8 cycles starting 2 edges after the last handshake; `x` = 10,14,12,16,11,15,13,17; then `frames_sent` = 1.
- **Back-pressure (GAP=16):** push 24 samples with `s_valid` held high → `s_ready` drops after the 16th sample until frame 1's last beat ends; three frames emitted with first beats exactly 16 cycles apart; output contents match the bit-reversed inputs.
- **Bubbles:** `s_valid` toggling 1,0,0,1,… over 16 samples → two correct frames; `readyin` beats remain contiguous.
- **Reset mid-SEND:** assert `n_rst` during beat 3 → `readyin` = 0 after that edge; remaining beats are never emitted; a fresh 8-sample frame afterwards is emitted correctly; `frames_sent` = 1.
- **Wrap:** run 256 frames → `frames_sent` returns to 0.
